// File: rtl/gauss_decimate.sv
// 2:1 horizontal and vertical decimation of the blurred pixel stream into the next pyramid level.
// Define GAUSS_DECIMATE_AVG_EN to average each horizontal pixel pair instead of picking the even pixel.
module gauss_decimate #(
    parameter int PIXELS_PER_BEAT = 16,
    parameter int IMAGE_DIM       = 512,
    parameter int DATA_WIDTH      = 8 * PIXELS_PER_BEAT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  in_valid,
    input  logic                  in_sof,
    input  logic [DATA_WIDTH-1:0] inp_frame,
    output logic [DATA_WIDTH-1:0] out_frame,
    output logic                  out_valid,
    output logic                  out_last
);

    localparam int COUNTER_MAX = IMAGE_DIM / PIXELS_PER_BEAT;
    localparam int HALF        = PIXELS_PER_BEAT / 2;
    localparam int HALF_W      = 8 * HALF;
    localparam int COL_W       = (COUNTER_MAX > 1) ? $clog2(COUNTER_MAX) : 1;
    localparam int ROW_W       = (IMAGE_DIM > 1) ? $clog2(IMAGE_DIM) : 1;

    logic [COL_W-1:0]  col_cnt;
    logic [ROW_W-1:0]  row_cnt;
    logic [COL_W-1:0]  col_eff;
    logic [ROW_W-1:0]  row_eff;
    logic [HALF_W-1:0] pack_p0;
    logic [HALF_W-1:0] sel;
    logic              accept;

`ifdef GAUSS_DECIMATE_AVG_EN
    // Rounded mean of two pixels; the 9-bit sum shifted right always fits in 8 bits.
    function automatic logic [7:0] avg_round(input logic [7:0] a, input logic [7:0] b);
        return 8'(({1'b0, a} + {1'b0, b} + 9'd1) >> 1);
    endfunction

    always_comb begin
        sel = '0;
        for (int i = 0; i < HALF; i++) begin
            sel[8*i +: 8] = avg_round(inp_frame[16*i +: 8], inp_frame[16*i+8 +: 8]);
        end
    end
`else
    logic [HALF_W-1:0] unused_odd;

    always_comb begin
        sel        = '0;
        unused_odd = '0;
        for (int i = 0; i < HALF; i++) begin
            sel[8*i +: 8]        = inp_frame[16*i +: 8];
            unused_odd[8*i +: 8] = inp_frame[16*i+8 +: 8];
        end
    end
`endif

    assign accept  = in_valid & ~stall;
    // A start-of-frame beat is always positioned at (row 0, col 0).
    assign col_eff = in_sof ? '0 : col_cnt;
    assign row_eff = in_sof ? '0 : row_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            col_cnt   <= '0;
            row_cnt   <= '0;
            pack_p0   <= '0;
            out_frame <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (!stall) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (accept) begin
                if (col_eff == COL_W'(COUNTER_MAX - 1)) begin
                    col_cnt <= '0;
                    row_cnt <= (row_eff == ROW_W'(IMAGE_DIM - 1)) ? '0 : row_eff + 1'b1;
                end else begin
                    col_cnt <= col_eff + 1'b1;
                    row_cnt <= row_eff;
                end
                // Odd rows are dropped; even rows pair an even-col beat with the following odd-col beat.
                if (!row_eff[0]) begin
                    if (!col_eff[0]) begin
                        pack_p0 <= sel;
                    end else begin
                        out_frame <= {sel, pack_p0};
                        out_valid <= 1'b1;
                        out_last  <= (row_eff == ROW_W'(IMAGE_DIM - 2)) &&
                                     (col_eff == COL_W'(COUNTER_MAX - 1));
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_gauss_decimate.sv
// Directed self-checking bench for gauss_decimate at default parameters.
module tb_gauss_decimate;

    localparam int PPB  = 16;
    localparam int DIM  = 512;
    localparam int DW   = 8 * PPB;
    localparam int CM   = DIM / PPB;
    localparam int HALF = PPB / 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          stall;
    logic          in_valid;
    logic          in_sof;
    logic [DW-1:0] inp_frame;
    logic [DW-1:0] out_frame;
    logic          out_valid;
    logic          out_last;

    int checks = 0;
    int errors = 0;

    gauss_decimate #(.PIXELS_PER_BEAT(PPB), .IMAGE_DIM(DIM), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset(reset), .stall(stall), .in_valid(in_valid), .in_sof(in_sof),
        .inp_frame(inp_frame), .out_frame(out_frame), .out_valid(out_valid), .out_last(out_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] fill(input logic [7:0] v);
        return {PPB{v}};
    endfunction

    // Apply one cycle of inputs, let the edge happen, then settle before sampling.
    task automatic cyc(input logic v, input logic sof, input logic st, input logic [DW-1:0] d);
        in_valid  = v;
        in_sof    = sof;
        stall     = st;
        inp_frame = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, '0);
        cyc(1'b0, 1'b0, 1'b0, '0);
        reset = 1'b0;
    endtask

    function automatic logic [DW-1:0] ramp(input int col);
        logic [DW-1:0] b;
        for (int k = 0; k < PPB; k++) b[8*k +: 8] = 8'((col * PPB + k) % 256);
        return b;
    endfunction

    logic [DW-1:0] exp1, exp2, avg_in, avg_exp;
    int pulses, bad, last_at, last_cnt;
    int avg_add;

    initial begin
        reset = 1'b1; stall = 1'b0; in_valid = 1'b0; in_sof = 1'b0; inp_frame = '0;
`ifdef GAUSS_DECIMATE_AVG_EN
        avg_add = 1;
`else
        avg_add = 0;
`endif
        // Ramp: out pixel i = pixel 2i (rounded mean with the odd neighbour adds 1 when averaging).
        for (int i = 0; i < PPB; i++) begin
            exp1[8*i +: 8] = 8'(2 * i + avg_add);
            exp2[8*i +: 8] = 8'(32 + 2 * i + avg_add);
        end

        do_reset();
        check("rst_frame", out_frame, '0);
        check("rst_valid", DW'(out_valid), '0);
        check("rst_last", DW'(out_last), '0);

        // Ramp on row 0
        cyc(1'b1, 1'b1, 1'b0, ramp(0));
        check("ramp_c0_valid", DW'(out_valid), '0);
        cyc(1'b1, 1'b0, 1'b0, ramp(1));
        check("ramp_c1_valid", DW'(out_valid), DW'(1));
        check("ramp_c1_data", out_frame, exp1);
        cyc(1'b1, 1'b0, 1'b0, ramp(2));
        check("ramp_c2_valid", DW'(out_valid), '0);
        check("ramp_c2_hold", out_frame, exp1);
        cyc(1'b1, 1'b0, 1'b0, ramp(3));
        check("ramp_c3_valid", DW'(out_valid), DW'(1));
        check("ramp_c3_data", out_frame, exp2);
        check("ramp_c3_last", DW'(out_last), '0);

        // Stall between col 0 and col 1
        do_reset();
        cyc(1'b1, 1'b1, 1'b0, ramp(0));
        for (int s = 0; s < 5; s++) begin
            cyc(1'b1, 1'b0, 1'b1, ramp(1));
            check("stall_novalid", DW'(out_valid), '0);
        end
        cyc(1'b1, 1'b0, 1'b0, ramp(1));
        check("stall_valid", DW'(out_valid), DW'(1));
        check("stall_data", out_frame, exp1);
        cyc(1'b1, 1'b0, 1'b1, ramp(2));
        cyc(1'b1, 1'b0, 1'b1, ramp(2));
        check("stall_held_valid", DW'(out_valid), DW'(1));
        check("stall_held_data", out_frame, exp1);
        cyc(1'b0, 1'b0, 1'b0, ramp(2));
        check("stall_release_valid", DW'(out_valid), '0);
        // col 2 was never accepted, so cols 2,3 still pair into the second beat
        cyc(1'b1, 1'b0, 1'b0, ramp(2));
        cyc(1'b1, 1'b0, 1'b0, ramp(3));
        check("stall_c3_data", out_frame, exp2);

        // Row parity over a full frame
        do_reset();
        pulses = 0; bad = 0; last_at = 0; last_cnt = 0;
        for (int r = 0; r < DIM; r++) begin
            for (int c = 0; c < CM; c++) begin
                cyc(1'b1, (r == 0 && c == 0), 1'b0, (r % 2 == 0) ? fill(8'h10) : fill(8'hFF));
                if (out_valid) begin
                    pulses++;
                    if (out_frame !== fill(8'h10)) bad++;
                    if (out_last) begin
                        last_cnt++;
                        last_at = pulses;
                    end
                end else if (out_last) begin
                    bad++;
                end
            end
        end
        check("frame_pulses", DW'(pulses), DW'(4096));
        check("frame_bad_pixels", DW'(bad), '0);
        check("frame_last_count", DW'(last_cnt), DW'(1));
        check("frame_last_pos", DW'(last_at), DW'(4096));
        cyc(1'b1, 1'b0, 1'b0, fill(8'h20));
        check("wrap_c0_valid", DW'(out_valid), '0);
        cyc(1'b1, 1'b0, 1'b0, fill(8'h21));
        check("wrap_c1_valid", DW'(out_valid), DW'(1));
        check("wrap_c1_data", out_frame, {{HALF{8'h21}}, {HALF{8'h20}}});

        // Resync with in_sof at row 6, col 5
        do_reset();
        for (int n = 0; n < 6 * CM + 5; n++) cyc(1'b1, (n == 0), 1'b0, fill(8'h55));
        cyc(1'b1, 1'b1, 1'b0, fill(8'h33));
        check("resync_sof_valid", DW'(out_valid), '0);
        cyc(1'b1, 1'b0, 1'b0, fill(8'h77));
        check("resync_pair_valid", DW'(out_valid), DW'(1));
        check("resync_pair_data", out_frame, {{HALF{8'h77}}, {HALF{8'h33}}});

        // Reset mid-row at row 2, col 3
        do_reset();
        for (int n = 0; n < 2 * CM + 3; n++) cyc(1'b1, (n == 0), 1'b0, fill(8'h44));
        check("prerst_frame", out_frame, fill(8'h44));
        reset = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, fill(8'h44));
        reset = 1'b0;
        check("midrst_frame", out_frame, '0);
        check("midrst_valid", DW'(out_valid), '0);
        check("midrst_last", DW'(out_last), '0);
        cyc(1'b1, 1'b0, 1'b0, fill(8'h66));
        check("postrst_c0_valid", DW'(out_valid), '0);
        cyc(1'b1, 1'b0, 1'b0, fill(8'h99));
        check("postrst_c1_valid", DW'(out_valid), DW'(1));
        check("postrst_c1_data", out_frame, {{HALF{8'h99}}, {HALF{8'h66}}});

        // Horizontal pair handling: pairs (10,20), (10,11), (255,255), rest (0,0)
        do_reset();
        avg_in = '0;
        avg_in[7:0] = 8'd10;  avg_in[15:8]  = 8'd20;
        avg_in[23:16] = 8'd10; avg_in[31:24] = 8'd11;
        avg_in[39:32] = 8'd255; avg_in[47:40] = 8'd255;
        avg_exp = '0;
`ifdef GAUSS_DECIMATE_AVG_EN
        avg_exp[7:0] = 8'd15; avg_exp[15:8] = 8'd11; avg_exp[23:16] = 8'd255;
`else
        avg_exp[7:0] = 8'd10; avg_exp[15:8] = 8'd10; avg_exp[23:16] = 8'd255;
`endif
        cyc(1'b1, 1'b1, 1'b0, avg_in);
        cyc(1'b1, 1'b0, 1'b0, '0);
        check("pair_data", out_frame, avg_exp);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
